// File: rtl/tt_scan_pkg.sv
// Shared types and sizes for the truth-table scanner (tt_scan) and its settle counter.
package tt_scan_pkg;

  localparam int NUM_MINTERMS = 16;
  localparam int IDX_W        = 4;
  localparam int CNT_W        = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_FINISH
  } state_e;

endpackage

// File: rtl/tt_settle_cnt.sv
// Settle down-counter: loadable, decrements toward zero, flags when the next value is zero.
module tt_settle_cnt
  import tt_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Zero flag of the value being written, so the owner can leave on the edge it reaches 0.
  assign zero_o = (cnt_d == '0);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/tt_scan.sv
// Truth-table scanner: walks 16 minterms, samples f_in, compares against an expected table.
// Optional second-implementation equivalence check enabled by defining TT_SCAN_DUAL_EN.
module tt_scan
  import tt_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_MINTERMS-1:0] expected,
  output logic [IDX_W-1:0]        abcd,
  input  logic                    f_in,
`ifdef TT_SCAN_DUAL_EN
  input  logic                    g_in,
  output logic                    equiv,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [NUM_MINTERMS-1:0] result,
  output logic [4:0]              mismatches
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_MINTERMS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC);
  localparam state_e           FIRST_STEP = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_MINTERMS-1:0] exp_q, exp_d;
  logic [NUM_MINTERMS-1:0] result_q, result_d;
  logic [4:0]              mism_q, mism_d;
  logic                    pass_q, pass_d;
  logic                    equiv_q, equiv_d;
  logic                    mismatch_now;
  logic                    diff_now;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  // Counter controls depend only on registered state so the zero flag never loops back.
  assign cnt_load = ((state_q == S_IDLE) && start) ||
                    ((state_q == S_SAMPLE) && (idx_q != LAST_IDX));
  assign cnt_dec  = (state_q == S_SETTLE);

  tt_settle_cnt u_settle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (SETTLE_LD),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  assign mismatch_now = (f_in != exp_q[idx_q]);
`ifdef TT_SCAN_DUAL_EN
  assign diff_now = (g_in != f_in);
`else
  assign diff_now = 1'b0;
`endif

  // NOTE: every combinational output gets a hold default first, so no latches are inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    result_d = result_q;
    mism_d   = mism_q;
    pass_d   = pass_q;
    equiv_d  = equiv_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d    = expected;
          idx_d    = '0;
          result_d = '0;
          mism_d   = '0;
          pass_d   = 1'b0;
          equiv_d  = 1'b1;
          state_d  = FIRST_STEP;
        end
      end
      S_SETTLE: begin
        if (cnt_zero) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        result_d[idx_q] = f_in;
        if (mismatch_now) mism_d = mism_q + 5'd1;
        if (diff_now) equiv_d = 1'b0;
        if (idx_q == LAST_IDX) begin
          // Pass is resolved here so it is already valid while done is high.
`ifdef TT_SCAN_DUAL_EN
          pass_d = (mism_d == '0) && equiv_d;
`else
          pass_d = (mism_d == '0);
`endif
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FIRST_STEP;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      mism_q   <= '0;
      pass_q   <= 1'b0;
      equiv_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      mism_q   <= mism_d;
      pass_q   <= pass_d;
      equiv_q  <= equiv_d;
    end
  end

  assign busy       = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign abcd       = busy ? idx_q : '0;
  assign done       = (state_q == S_FINISH);
  assign pass       = pass_q;
  assign result     = result_q;
  assign mismatches = mism_q;
`ifdef TT_SCAN_DUAL_EN
  assign equiv      = equiv_q;
`endif

endmodule

// File: tb/tb_tt_scan.sv
// Self-checking bench for tt_scan: two instances (SETTLE_CYC 0 and 2) driven from a scoreboard.
module tb_tt_scan;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  mism;
    logic        pass;
    logic        equiv;
    int          lat;
  } exp_t;

  exp_t sb[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sel;
  logic [15:0] expected;
  logic [15:0] fmask;
  logic        inv5;

  logic        start0, start2;
  logic [3:0]  abcd0, abcd2;
  logic        f0, f2;
  logic        busy0, busy2, done0, done2, pass0, pass2;
  logic [15:0] result0, result2;
  logic [4:0]  mism0, mism2;
  logic        equiv0, equiv2;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start2 = start & sel;
  assign f0     = fmask[abcd0];
  assign f2     = fmask[abcd2];

`ifdef TT_SCAN_DUAL_EN
  logic g0, g2;
  assign g0 = fmask[abcd0] ^ (inv5 && (abcd0 == 4'd5));
  assign g2 = fmask[abcd2] ^ (inv5 && (abcd2 == 4'd5));
`else
  assign equiv0 = 1'b0;
  assign equiv2 = 1'b0;
`endif

  tt_scan #(.SETTLE_CYC(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start0),
    .expected   (expected),
    .abcd       (abcd0),
    .f_in       (f0),
`ifdef TT_SCAN_DUAL_EN
    .g_in       (g0),
    .equiv      (equiv0),
`endif
    .busy       (busy0),
    .done       (done0),
    .pass       (pass0),
    .result     (result0),
    .mismatches (mism0)
  );

  tt_scan #(.SETTLE_CYC(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .expected   (expected),
    .abcd       (abcd2),
    .f_in       (f2),
`ifdef TT_SCAN_DUAL_EN
    .g_in       (g2),
    .equiv      (equiv2),
`endif
    .busy       (busy2),
    .done       (done2),
    .pass       (pass2),
    .result     (result2),
    .mismatches (mism2)
  );

  // Selected-instance view used by the scan tasks.
  logic [3:0]  abcd_s;
  logic        busy_s, done_s, pass_s, equiv_s;
  logic [15:0] result_s;
  logic [4:0]  mism_s;
  assign abcd_s   = sel ? abcd2   : abcd0;
  assign busy_s   = sel ? busy2   : busy0;
  assign done_s   = sel ? done2   : done0;
  assign pass_s   = sel ? pass2   : pass0;
  assign equiv_s  = sel ? equiv2  : equiv0;
  assign result_s = sel ? result2 : result0;
  assign mism_s   = sel ? mism2   : mism0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard entry from a reference model of the scan.
  function automatic exp_t model(input logic [15:0] exp_tt, input logic [15:0] mask,
                                 input logic s, input logic inv);
    exp_t e;
    e.res  = '0;
    e.mism = '0;
    for (int i = 0; i < 16; i++) begin
      e.res[i] = mask[i];
      if (mask[i] != exp_tt[i]) e.mism = e.mism + 5'd1;
    end
`ifdef TT_SCAN_DUAL_EN
    e.equiv = !inv;
    e.pass  = (e.mism == 0) && !inv;
`else
    e.equiv = 1'b0;
    e.pass  = (e.mism == 0);
`endif
    e.lat = s ? 49 : 17;
    return e;
  endfunction

  task automatic run_scan(input string tag, input logic s, input logic [15:0] exp_tt,
                          input logic [15:0] mask, input int restart_at);
    exp_t e;
    int   n;
    bit   restarted;
    sel      = s;
    expected = exp_tt;
    fmask    = mask;
    sb.push_back(model(exp_tt, mask, s, inv5));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy_on"}, busy_s, 1'b1);
    restarted = 1'b0;
    while (!done_s && n < 200) begin
      if (!restarted && busy_s && (int'(abcd_s) == restart_at)) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, ".done_seen"}, done_s, 1'b1);
    e = sb.pop_front();
    check({tag, ".latency"}, n, e.lat);
    check({tag, ".result"}, result_s, e.res);
    check({tag, ".mismatches"}, mism_s, e.mism);
    check({tag, ".pass"}, pass_s, e.pass);
    check({tag, ".busy_at_done"}, busy_s, 1'b0);
`ifdef TT_SCAN_DUAL_EN
    check({tag, ".equiv"}, equiv_s, e.equiv);
`endif
    @(negedge clk);
    check({tag, ".done_pulse"}, done_s, 1'b0);
    check({tag, ".pass_hold"}, pass_s, e.pass);
    check({tag, ".abcd_idle"}, abcd_s, 4'd0);
  endtask

  initial begin
    int  n;
    bit  saw_done;
    rst_n    = 1'b1;
    start    = 1'b0;
    sel      = 1'b0;
    inv5     = 1'b0;
    expected = '0;
    fmask    = '0;

    // Scramble state before the first reset.
    repeat (6) begin
      @(negedge clk);
      start    = 1'($urandom);
      sel      = 1'($urandom);
      expected = 16'($urandom);
      fmask    = 16'($urandom);
    end
    start = 1'b0;
    sel   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.abcd0",   abcd0,   4'd0);
    check("rst.busy0",   busy0,   1'b0);
    check("rst.done0",   done0,   1'b0);
    check("rst.pass0",   pass0,   1'b0);
    check("rst.result0", result0, 16'd0);
    check("rst.mism0",   mism0,   5'd0);
    check("rst.abcd2",   abcd2,   4'd0);
    check("rst.busy2",   busy2,   1'b0);
    check("rst.result2", result2, 16'd0);
    check("rst.mism2",   mism2,   5'd0);
`ifdef TT_SCAN_DUAL_EN
    check("rst.equiv0",  equiv0,  1'b0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run_scan("match_s0",   1'b0, 16'hACBA, 16'hACBA, -1);
    run_scan("match_s2",   1'b1, 16'hACBA, 16'hACBA, -1);
    run_scan("onebad_s0",  1'b0, 16'hACBB, 16'hACBA, -1);
    run_scan("allbad_s0",  1'b0, 16'hFFFF, 16'h0000, -1);
    run_scan("allbad_s2",  1'b1, 16'hFFFF, 16'h0000, -1);
    run_scan("restart_s0", 1'b0, 16'hACBA, 16'hACBA, 5);
    run_scan("restart_s2", 1'b1, 16'h1234, 16'hACBA, 5);

    // Abort a scan with reset at minterm 7.
    sel      = 1'b0;
    expected = 16'hACBA;
    fmask    = 16'hACBA;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (abcd0 != 4'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort.reach_idx7", abcd0, 4'd7);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort.busy",  busy0, 1'b0);
    check("abort.abcd",  abcd0, 4'd0);
    check("abort.done",  done0, 1'b0);
    check("abort.mism",  mism0, 5'd0);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done0) saw_done = 1'b1;
    end
    check("abort.no_done", saw_done, 1'b0);
    run_scan("after_abort_s0", 1'b0, 16'h5A5A, 16'hACBA, -1);

`ifdef TT_SCAN_DUAL_EN
    inv5 = 1'b1;
    run_scan("dual_inv5_s0", 1'b0, 16'hACBA, 16'hACBA, -1);
    run_scan("dual_inv5_s2", 1'b1, 16'hACBA, 16'hACBA, -1);
    inv5 = 1'b0;
    run_scan("dual_ok_s0",   1'b0, 16'hACBA, 16'hACBA, -1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tt_scan.md
TT_SCAN -- requirements
Module: tt_scan

Interface
REQ-001 Parameter SETTLE_CYC, default 0, wait cycles between driving a minterm index and sampling f_in (range 0..7).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin a 16-minterm scan; sampled only in IDLE.
REQ-005 expected  input  16  expected truth table, bit i = f(i); latched when start is accepted.
REQ-006 abcd  output  4  minterm index driven to the function under test, abcd[3]=a, abcd[0]=d.
REQ-007 f_in  input  1  function output returned from the function under test.
REQ-008 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-009 done  output  1  one-cycle pulse at scan end.
REQ-010 pass  output  1  1 = scan matched; valid from done, held until next accepted start.
REQ-011 result  output  16  captured truth table, bit i = f_in sampled at index i.
REQ-012 mismatches  output  5  count of minterms where f_in != expected bit, 0..16.

Function
REQ-013 FSM states IDLE, SETTLE, SAMPLE, FINISH; busy = (state is SETTLE or SAMPLE).
REQ-014 IDLE + start: latch expected, idx=0, clear result/mismatches/pass, load settle counter with SETTLE_CYC; go to SETTLE, or directly to SAMPLE when SETTLE_CYC=0.
REQ-015 SETTLE: abcd=idx, counter decrements each cycle; leave for SAMPLE on the cycle the counter reaches 0.
REQ-016 SAMPLE (one cycle): result[idx]<=f_in; mismatches increments if f_in != expected_q[idx]; if idx==15 go FINISH, else idx+1, reload counter, go to SETTLE (SAMPLE if SETTLE_CYC=0).
REQ-017 FINISH: done=1 for exactly one cycle, pass=(final mismatches==0); return to IDLE next cycle.
REQ-018 Latency: done is high in the cycle after rising edge 16*(SETTLE_CYC+1)+1 counted from the edge that accepts start (SETTLE_CYC=0 -> edge 17).
REQ-019 start while busy or in FINISH is ignored; no restart, no queueing.
REQ-020 In IDLE/FINISH, abcd holds 0; result, mismatches and pass hold their last values.
REQ-021 idx never wraps past 15; mismatches saturates naturally at 16 (5-bit width, no overflow).

Reset
REQ-022 rst_n=0 at a rising edge: state=IDLE, abcd=0, busy=0, done=0, pass=0, result=0, mismatches=0, internal idx/counter/expected_q=0.
REQ-023 Reset mid-scan aborts the scan with no done pulse; the next start runs a full scan.

Configuration
REQ-024 Macro TT_SCAN_DUAL_EN: when defined, adds input g_in (1, second implementation of the same function) and output equiv (1); equiv is set to 1 at start, cleared at any SAMPLE where g_in != f_in, and reset to 0 by rst_n; pass additionally requires equiv=1.
REQ-025 Without TT_SCAN_DUAL_EN, ports g_in and equiv do not exist and pass depends only on mismatches.

Structure
REQ-026 Package tt_scan_pkg holds the state enum, NUM_MINTERMS=16, IDX_W=4, CNT_W=5.
REQ-027 The settle down-counter is the single sub-module, tt_settle_cnt (load, decrement, zero flag).

Verification
REQ-028 rst_n low 2 cycles from random state -> all outputs 0, state IDLE.
REQ-029 f_in modelled as mask 0xACBA, expected=0xACBA, SETTLE_CYC=0 -> done after edge 17, result=0xACBA, mismatches=0, pass=1; repeat with SETTLE_CYC=2 -> done after edge 49, same results.
REQ-030 Same DUT model, expected=0xACBB -> result=0xACBA, mismatches=1, pass=0.
REQ-031 f_in tied 0, expected=0xFFFF -> mismatches=16, result=0x0000, pass=0.
REQ-032 start pulsed again at idx=5 -> ignored, done timing unchanged; rst_n low at idx=7 -> busy=0, abcd=0, no done; the following start completes normally.
REQ-033 With TT_SCAN_DUAL_EN, g_in = f_in except inverted at minterm 5, expected=0xACBA -> mismatches=0, equiv=0, pass=0.
